// File: rtl/uart_os16_link.sv
// uart_os16_link: self-contained 8N1 UART transceiver.
//
// The transmitter is paced by a divider tick once per bit. The receiver is
// paced by a 16x oversample tick, samples each bit in the middle and checks
// the stop bit.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   start         transmit request; accepted only while the transmitter is idle
//   data_in       byte to send, captured when start is accepted
//   tx_line       serial output, idle high
//   busy          transmitter occupied
//   done          one-cycle pulse at the end of the stop bit
//   rx_line       asynchronous serial input
//   data_out      last received byte, held until the next frame completes
//   valid         one-cycle pulse when a received frame completes
//   framing_error stop-bit status of the last completed frame (1 = bad stop)
module uart_os16_link #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       tx_line,
  output logic       busy,
  output logic       done,
  input  logic       rx_line,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       framing_error
);

  localparam int DIV_TX = (CLK_HZ + BAUD/2) / BAUD;
  localparam int DIV_OS = (CLK_HZ + 8*BAUD) / (16*BAUD);
  localparam int CW     = (DIV_TX > 2) ? $clog2(DIV_TX) : 1;
  localparam logic [CW-1:0] TX_LAST = CW'(DIV_TX - 1);
  localparam logic [CW-1:0] OS_LAST = CW'(DIV_OS - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK_WAIT} rx_state_t;

  logic [CW-1:0] tx_cnt_q, os_cnt_q;
  logic          baud_tick, os_tick;

  tx_state_t tx_state_q, tx_state_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [2:0] tx_idx_q, tx_idx_d;
  logic       tx_line_d, busy_d, done_d;

  rx_state_t rx_state_q, rx_state_d;
  logic       sync1_q, rx_s;
  logic [3:0] sub_q, sub_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] data_out_d;
  logic       valid_d, fe_d;

  assign baud_tick = (tx_cnt_q == TX_LAST);
  assign os_tick   = (os_cnt_q == OS_LAST);

  // Free-running dividers; the two tick rates are unrelated to each other.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_cnt_q <= '0;
      os_cnt_q <= '0;
    end else begin
      tx_cnt_q <= baud_tick ? '0 : tx_cnt_q + 1'b1;
      os_cnt_q <= os_tick   ? '0 : os_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      tx_idx_q   <= '0;
      tx_line    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_idx_q   <= tx_idx_d;
      tx_line    <= tx_line_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // WAIT aligns the start bit to the free-running baud tick so that every
  // bit, including the start bit, is exactly one divider period long.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_idx_d   = tx_idx_q;
    tx_line_d  = tx_line;
    busy_d     = busy;
    done_d     = 1'b0;
    case (tx_state_q)
      TX_IDLE: if (start) begin
        tx_shift_d = data_in;
        busy_d     = 1'b1;
        tx_state_d = TX_WAIT;
      end
      TX_WAIT: if (baud_tick) begin
        tx_line_d  = 1'b0;
        tx_state_d = TX_START;
      end
      TX_START: if (baud_tick) begin
        tx_line_d  = tx_shift_q[0];
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        tx_idx_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (baud_tick) begin
        if (tx_idx_q == 3'd7) begin
          tx_line_d  = 1'b1;
          tx_state_d = TX_STOP;
        end else begin
          tx_line_d  = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_idx_d   = tx_idx_q + 3'd1;
        end
      end
      TX_STOP: if (baud_tick) begin
        done_d     = 1'b1;
        busy_d     = 1'b0;
        tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Synchronizer resets to the idle (high) line level so reset never looks
  // like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q       <= 1'b1;
      rx_s          <= 1'b1;
      rx_state_q    <= RX_IDLE;
      sub_q         <= '0;
      bit_q         <= '0;
      rx_shift_q    <= '0;
      data_out      <= '0;
      valid         <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      sync1_q       <= rx_line;
      rx_s          <= sync1_q;
      rx_state_q    <= rx_state_d;
      sub_q         <= sub_d;
      bit_q         <= bit_d;
      rx_shift_q    <= rx_shift_d;
      data_out      <= data_out_d;
      valid         <= valid_d;
      framing_error <= fe_d;
    end
  end

  // Receiver: START confirms the start bit at its middle, after which every
  // 16th oversample tick lands mid-bit. A good stop bit returns to IDLE at
  // mid stop bit to allow resync; a bad one waits for the line to go high.
  always_comb begin
    rx_state_d = rx_state_q;
    sub_d      = sub_q;
    bit_d      = bit_q;
    rx_shift_d = rx_shift_q;
    data_out_d = data_out;
    valid_d    = 1'b0;
    fe_d       = framing_error;
    if (os_tick) begin
      case (rx_state_q)
        RX_IDLE: if (!rx_s) begin
          sub_d      = '0;
          rx_state_d = RX_START;
        end
        RX_START: begin
          if (sub_q == 4'd7) begin
            sub_d      = '0;
            bit_d      = '0;
            rx_state_d = rx_s ? RX_IDLE : RX_DATA;
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
        RX_DATA: begin
          sub_d = sub_q + 4'd1;
          if (sub_q == 4'd15) begin
            rx_shift_d = {rx_s, rx_shift_q[7:1]};
            if (bit_q == 3'd7) rx_state_d = RX_STOP;
            else               bit_d = bit_q + 3'd1;
          end
        end
        RX_STOP: begin
          sub_d = sub_q + 4'd1;
          if (sub_q == 4'd15) begin
            data_out_d = rx_shift_q;
            valid_d    = 1'b1;
            fe_d       = ~rx_s;
            rx_state_d = rx_s ? RX_IDLE : RX_BREAK_WAIT;
          end
        end
        RX_BREAK_WAIT: if (rx_s) rx_state_d = RX_IDLE;
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_os16_link.sv
// Testbench for uart_os16_link at default parameters (434 clk per bit,
// 27 clk per oversample tick). rx_line is either looped back from tx_line
// or driven directly by the bench.
module tb_uart_os16_link;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx_line, busy, done, rx_line, valid, framing_error;
  logic [7:0] data_out;

  logic loop_en = 1'b1;
  logic rx_drv  = 1'b1;

  assign rx_line = loop_en ? tx_line : rx_drv;

  always #5 clk = ~clk;

  uart_os16_link dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .tx_line(tx_line), .busy(busy), .done(done), .rx_line(rx_line),
    .data_out(data_out), .valid(valid), .framing_error(framing_error)
  );

  typedef struct {
    logic [7:0] tx_byte;
    logic [7:0] exp_data;
    logic       exp_fe;
    int         exp_low_run;
  } vec_t;

  int checks = 0;
  int failures = 0;

  int         valid_cnt = 0;
  int         done_cnt = 0;
  int         run_cur = 0;
  int         last_low_run = 0;
  logic [7:0] cap_data = 8'h00;
  logic       cap_fe = 1'b0;
  logic       busy_at_done = 1'b0;

  // Observe the DUT on the falling edge: count pulses, capture received
  // bytes and measure the length of each low run on tx_line in clocks.
  always @(negedge clk) begin
    if (!rst) run_cur = 0;
    else if (tx_line == 1'b0) run_cur++;
    else if (run_cur != 0) begin
      last_low_run = run_cur;
      run_cur = 0;
    end
    if (valid) begin
      valid_cnt++;
      cap_data = data_out;
      cap_fe = framing_error;
    end
    if (done) begin
      done_cnt++;
      busy_at_done = busy;
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic start_frame(input logic [7:0] b);
    int n = 0;
    while (busy && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check_output("busy_idle_timeout", int'(busy), 0);
    @(negedge clk);
    start = 1'b1;
    data_in = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int prev, input int budget);
    int n = 0;
    while (valid_cnt == prev && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_output("valid_timeout", int'(valid_cnt != prev), 1);
  endtask

  task automatic wait_done(input int prev, input int budget);
    int n = 0;
    while (done_cnt == prev && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_output("done_timeout", int'(done_cnt != prev), 1);
  endtask

  // Send one byte over the loopback and check the received frame, the
  // pulse counts, busy at done, and the last low run seen on tx_line.
  task automatic apply_stimulus(input vec_t v);
    int pv, pd;
    pv = valid_cnt;
    pd = done_cnt;
    start_frame(v.tx_byte);
    wait_valid(pv, 6000);
    wait_done(pd, 1500);
    repeat (2) @(posedge clk);
    check_output($sformatf("data_%02h", v.tx_byte), int'(cap_data), int'(v.exp_data));
    check_output($sformatf("fe_%02h", v.tx_byte), int'(cap_fe), int'(v.exp_fe));
    check_output($sformatf("valid_count_%02h", v.tx_byte), valid_cnt - pv, 1);
    check_output($sformatf("done_count_%02h", v.tx_byte), done_cnt - pd, 1);
    check_output($sformatf("busy_at_done_%02h", v.tx_byte), int'(busy_at_done), 0);
    check_output($sformatf("low_run_%02h", v.tx_byte), last_low_run, v.exp_low_run);
  endtask

  vec_t vecs[4];
  vec_t v3c;

  initial begin
    int pv;

    // LSB first: B3 -> 1,1,0,0,1,1,0,1 (last low is bit6 alone);
    // 00 -> start + 8 data bits low = 9*434; FF -> start only;
    // 55 -> 1,0,1,0,1,0,1,0 (bit7 alone).
    vecs[0] = '{8'hB3, 8'hB3, 1'b0, 434};
    vecs[1] = '{8'h00, 8'h00, 1'b0, 3906};
    vecs[2] = '{8'hFF, 8'hFF, 1'b0, 434};
    vecs[3] = '{8'h55, 8'h55, 1'b0, 434};
    // 3C -> 0,0,1,1,1,1,0,0: last low run is bits 6..7.
    v3c     = '{8'h3C, 8'h3C, 1'b0, 868};

    repeat (3) @(negedge clk);
    check_output("reset_tx_line", int'(tx_line), 1);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_done", int'(done), 0);
    check_output("reset_data_out", int'(data_out), 0);
    check_output("reset_valid", int'(valid), 0);
    check_output("reset_fe", int'(framing_error), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 4; i++) apply_stimulus(vecs[i]);

    // start held while busy must not launch a second frame.
    $display("[TB] start while busy");
    pv = valid_cnt;
    start_frame(8'h66);
    repeat (200) @(negedge clk);
    start = 1'b1;
    data_in = 8'hAA;
    repeat (50) @(negedge clk);
    start = 1'b0;
    wait_valid(pv, 6000);
    wait_done(done_cnt - 1 + 1 - 1 + 1 - 1, 1);
    begin
      int n = 0;
      while (busy && n < 1500) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (2) @(negedge clk);
    check_output("busy_ignore_data", int'(cap_data), 8'h66);
    check_output("busy_ignore_busy", int'(busy), 0);
    repeat (600) @(negedge clk);
    check_output("busy_ignore_valid_count", valid_cnt - pv, 1);
    check_output("busy_ignore_busy_late", int'(busy), 0);

    // Line held low through the stop bit: framing error, then no new frame
    // while the line stays low.
    $display("[TB] break / framing error");
    loop_en = 1'b0;
    rx_drv = 1'b0;
    pv = valid_cnt;
    wait_valid(pv, 6000);
    @(negedge clk);
    check_output("break_data", int'(cap_data), 8'h00);
    check_output("break_fe", int'(cap_fe), 1);
    repeat (6000) @(negedge clk);
    check_output("break_no_new_frame", valid_cnt - pv, 1);
    rx_drv = 1'b1;
    repeat (300) @(negedge clk);

    // Five oversample ticks of low is a glitch, not a start bit.
    $display("[TB] glitch rejection");
    pv = valid_cnt;
    rx_drv = 1'b0;
    repeat (135) @(negedge clk);
    rx_drv = 1'b1;
    repeat (5000) @(negedge clk);
    check_output("glitch_no_valid", valid_cnt - pv, 0);
    check_output("glitch_fe_held", int'(framing_error), 1);
    loop_en = 1'b1;
    repeat (10) @(negedge clk);
    apply_stimulus(v3c);
    check_output("fe_cleared", int'(framing_error), 0);

    // Reset in the middle of a transmission.
    $display("[TB] reset mid-frame");
    start_frame(8'hB3);
    repeat (2000) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_output("midreset_tx_line", int'(tx_line), 1);
    check_output("midreset_busy", int'(busy), 0);
    check_output("midreset_data_out", int'(data_out), 0);
    check_output("midreset_valid", int'(valid), 0);
    check_output("midreset_fe", int'(framing_error), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    apply_stimulus(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
